// File: rtl/sr_mdu_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
// The divider is only built when SR_MDU_DIV_EN is defined.
package sr_mdu_pkg;

  localparam int MDU_ITER = 32;
  localparam int CNT_W    = $clog2(MDU_ITER);

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic sgn_a(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic sgn_b(input logic [2:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/sr_mdu_seq_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface sr_mdu_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      oper;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, oper, srcA, srcB, input busy, done, result);
  modport slave  (input start, oper, srcA, srcB, output busy, done, result);
endinterface

// File: rtl/sr_mdu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the
// divisor when it fits.
module sr_mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dbit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] sub;

  assign trial  = {rem_i, dbit_i};
  assign qbit_o = (trial >= {1'b0, divisor_i});
  // When the subtraction is taken the difference is below the divisor, so
  // the upper trial bit can be dropped.
  assign sub    = trial[XLEN-1:0] - divisor_i;
  assign rem_o  = qbit_o ? sub : trial[XLEN-1:0];
endmodule

// File: rtl/sr_mdu_seq.sv
// Iterative RV32M unit: 32-step shift-add multiply and restoring divide on
// operand magnitudes, sign fix at the end. Divide support: SR_MDU_DIV_EN.
module sr_mdu_seq
  import sr_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  sr_mdu_seq_if.slave  mdu
);
  mdu_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        oper_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q, busy_q, done_q;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  assign a_neg = sgn_a(mdu.oper) & mdu.srcA[XLEN-1];
  assign b_neg = sgn_b(mdu.oper) & mdu.srcB[XLEN-1];
  assign a_mag = a_neg ? -mdu.srcA : mdu.srcA;
  assign b_mag = b_neg ? -mdu.srcB : mdu.srcB;

  // Multiply walks the multiplier MSB-first so it shares the shift pattern
  // of the divider: acc = 2*acc + bit*a.
  logic [2*XLEN-1:0] mul_acc_d, acc_d, prod;
  logic [XLEN-1:0]   a_d, b_d, res_d;

  assign mul_acc_d = (acc_q << 1) + (b_q[XLEN-1] ? {{XLEN{1'b0}}, a_q} : '0);

`ifdef SR_MDU_DIV_EN
  logic [XLEN-1:0] rem_nxt;
  logic            q_bit;
  logic            spec_q;
  logic [XLEN-1:0] spec_val_q;
  logic            div_zero, div_ovf;

  assign div_zero = (mdu.srcB == '0);
  assign div_ovf  = (mdu.oper == OP_DIV || mdu.oper == OP_REM) &&
                    (mdu.srcA == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.srcB == '1);

  // Remainder lives in acc_q low half; quotient bits replace the dividend
  // bits as they shift out of a_q.
  sr_mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (acc_q[XLEN-1:0]),
    .dbit_i    (a_q[XLEN-1]),
    .divisor_i (b_q),
    .rem_o     (rem_nxt),
    .qbit_o    (q_bit)
  );

  always_comb begin
    acc_d = mul_acc_d;
    a_d   = a_q;
    b_d   = b_q << 1;
    if (is_div(oper_q)) begin
      acc_d = {{XLEN{1'b0}}, rem_nxt};
      a_d   = {a_q[XLEN-2:0], q_bit};
      b_d   = b_q;
    end
  end
`else
  assign acc_d = mul_acc_d;
  assign a_d   = a_q;
  assign b_d   = b_q << 1;
`endif

  assign prod = neg_q ? -acc_d : acc_d;

  always_comb begin
    res_d = (oper_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef SR_MDU_DIV_EN
    if (is_div(oper_q)) begin
      if (spec_q)         res_d = spec_val_q;
      else if (oper_q[1]) res_d = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
      else                res_d = neg_q ? -a_d : a_d;
    end
`else
    if (is_div(oper_q)) res_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      oper_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
`ifdef SR_MDU_DIV_EN
      spec_q     <= 1'b0;
      spec_val_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (mdu.start) begin
            state_q <= ST_CALC;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            oper_q  <= mdu.oper;
            a_q     <= a_mag;
            b_q     <= b_mag;
            acc_q   <= '0;
            // Signed REM follows the dividend; everything else the sign product.
            neg_q   <= (mdu.oper == OP_REM) ? a_neg : (a_neg ^ b_neg);
`ifdef SR_MDU_DIV_EN
            spec_q     <= is_div(mdu.oper) && (div_zero || div_ovf);
            spec_val_q <= div_zero ? (mdu.oper[1] ? mdu.srcA : '1)
                                   : (mdu.oper[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`endif
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MDU_ITER - 1)) begin
            state_q  <= ST_DONE;
            result_q <= res_d;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy   = busy_q;
  assign mdu.done   = done_q;
  assign mdu.result = result_q;
endmodule

// File: tb/tb_sr_mdu_seq.sv
// Scoreboard bench for sr_mdu_seq; expectations follow SR_MDU_DIV_EN.
module tb_sr_mdu_seq;
  import sr_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sr_mdu_seq_if #(.XLEN(32)) mdu ();

  sr_mdu_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu)
  );

  function automatic logic [31:0] exp_div(input logic [31:0] v);
`ifdef SR_MDU_DIV_EN
    return v;
`else
    return (v == v) ? 32'h0 : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    logic [31:0] r;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 32'h0;
    case (op)
      OP_MUL:    begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
      OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      OP_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); r = p[63:32]; end
      OP_MULHU:  begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      OP_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $signed(a) / $signed(b);
      OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    r = (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
      default:   r = (b == 0) ? a : a % b;
    endcase
    if (op[2]) r = exp_div(r);
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && mdu.done) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got=%h exp=none", mdu.result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (mdu.result !== e) begin
          failures++;
          $display("FAIL result got=%h exp=%h", mdu.result, e);
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int k;
    @(negedge clk);
    mdu.oper = op; mdu.srcA = a; mdu.srcB = b; mdu.start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    mdu.start = 1'b0; mdu.srcA = ~a; mdu.srcB = ~b;
    checks++;
    if (mdu.busy !== 1'b1) begin failures++; $display("FAIL busy_after_accept got=%b exp=1", mdu.busy); end
    k = 0;
    while (mdu.done !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    checks++;
    if (k !== 32) begin failures++; $display("FAIL latency op=%0d got=%0d exp=32", op, k); end
    @(posedge clk); #1;
    checks++;
    if (mdu.busy !== 1'b0 || mdu.done !== 1'b0 || mdu.result !== e) begin
      failures++;
      $display("FAIL idle_hold got=busy%b done%b res=%h exp=busy0 done0 res=%h", mdu.busy, mdu.done, mdu.result, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mdu.start = 1'b0; mdu.oper = '0; mdu.srcA = '0; mdu.srcB = '0;
    #1;
    checks++;
    if (mdu.busy !== 1'b0 || mdu.done !== 1'b0 || mdu.result !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got=busy%b done%b res=%h exp=busy0 done0 res=0", mdu.busy, mdu.done, mdu.result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, exp_div(32'hFFFF_FFFD));
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, exp_div(32'hFFFF_FFFF));
    run_op(OP_DIVU, 32'd100,       32'd7, exp_div(32'd14));
    run_op(OP_REMU, 32'd100,       32'd7, exp_div(32'd2));
    run_op(OP_DIV,  32'd9,         32'd3, exp_div(32'd3));
  endtask

  task automatic test_special();
    run_op(OP_DIV,  32'd5,         32'd0,         exp_div(32'hFFFF_FFFF));
    run_op(OP_REM,  32'd5,         32'd0,         exp_div(32'd5));
    run_op(OP_DIVU, 32'd5,         32'd0,         exp_div(32'hFFFF_FFFF));
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, exp_div(32'h8000_0000));
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, exp_div(32'h0));
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom();
      b = (i == 3) ? 32'h0 : $urandom() >> $urandom_range(0, 28);
      run_op(op, a, b, model(op, a, b));
    end
  endtask

  task automatic test_back_to_back();
    int k, gap, d0;
    d0 = done_cnt;
    @(negedge clk);
    mdu.oper = OP_MUL; mdu.srcA = 32'd5; mdu.srcB = 32'd6; mdu.start = 1'b1;
    exp_q.push_back(32'd30);
    @(posedge clk); #1;
    k = 0;
    repeat (10) begin @(posedge clk); #1; k++; end
    mdu.srcA = 32'd11;
    exp_q.push_back(model(OP_MUL, 32'd11, 32'd6));
    while (mdu.done !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    checks++;
    if (k !== 32) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=32", k); end
    gap = 0;
    while ((gap == 0 || mdu.done !== 1'b1) && gap < 50) begin @(posedge clk); #1; gap++; end
    checks++;
    if (gap !== 34) begin failures++; $display("FAIL b2b_throughput got=%0d exp=34", gap); end
    mdu.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (mdu.busy !== 1'b0 || done_cnt - d0 !== 2) begin
      failures++;
      $display("FAIL b2b_accept_count got=busy%b dones=%0d exp=busy0 dones=2", mdu.busy, done_cnt - d0);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    @(negedge clk);
    mdu.oper = OP_MULHU; mdu.srcA = 32'h1234_5678; mdu.srcB = 32'h9ABC_DEF0; mdu.start = 1'b1;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (mdu.busy !== 1'b0 || mdu.done !== 1'b0) begin
      failures++;
      $display("FAIL abort_immediate got=busy%b done%b exp=busy0 done0", mdu.busy, mdu.done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || mdu.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got=dones%0d busy%b exp=dones%0d busy0", done_cnt, mdu.busy, d0);
    end
    run_op(OP_MUL, 32'd123, 32'd456, 32'd56088);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_back_to_back();
    test_reset_abort();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sr_mdu_seq.md
# sr_mdu_seq

Iterative RV32M multiply/divide unit for the schoolRISCV core, fed by the same register-file operands as the single-cycle ALU. It runs alongside the ALU and delivers its result to the writeback mux. It replaces the combinational multiplier with a 32-iteration shift-add multiplier and restoring divider. While it runs, `busy` stalls the PC and register-file write.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: request pulse. Accepted only in IDLE.
- `oper` input 3: RV32M funct3 encoding, from `sr_mdu_pkg`.
- `srcA` input 32: rs1 operand. Sampled only when a start is accepted.
- `srcB` input 32: rs2 operand. Sampled only when a start is accepted.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: single-cycle pulse; `result` is valid in this cycle.
- `result` output 32: registered result. Held until the next `done`.

## Operation
- States and transitions:
  - IDLE → CALC on `start`.
  - CALC → CALC while `cnt` < 31.
  - CALC → DONE when `cnt` == 31.
  - DONE → IDLE unconditionally.
- On accept:
  - Latch `oper`.
  - Latch |srcA| and |srcB| according to the signedness of `oper`.
  - Latch the sign-fix flags.
  - Clear the 64-bit accumulator/remainder and `cnt`.
- `start` while `busy` is ignored; no queueing.
- Multiply:
  - One shift-add step per CALC cycle on the magnitudes.
  - A 64-bit product is negated at the end if the sign flag is set.
  - MUL returns bits [31:0].
  - MULH (s×s), MULHSU (s×u) and MULHU (u×u) return bits [63:32].
- Divide:
  - One restoring step per CALC cycle on the magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases are detected at accept. The result is forced and the latency is unchanged:
  - Divide by zero: DIV/DIVU → 0xFFFF_FFFF; REM/REMU → srcA.
  - Signed overflow (0x8000_0000 / 0xFFFF_FFFF): DIV → 0x8000_0000; REM → 0.
- `result` is loaded on the CALC→DONE edge.

## Timing
- `start` is accepted at edge E0.
- Iterations run at E1..E32, with `cnt` 0..31.
- DONE is entered at E32. `done` = 1 and `result` are valid between E32 and E33.
- IDLE is re-entered at E33. The earliest next accept is E34, so throughput is one op per 34 cycles.
- `busy` is high from E0 through E33 (E0 excluded on the combinational side).
- The core must treat `done` as the write-enable and the stall release.
- Reset values: IDLE, `busy` = 0, `done` = 0, `result` = 0, `cnt` = 0.
- `rst` asserted mid-operation aborts at once. No `done` pulse is produced and the operation is lost.
- `start` in the same cycle `rst` deasserts is ignored; the first valid start is one cycle after reset release.

## Configuration
- `SR_MDU_DIV_EN` defined: all eight RV32M operations are supported.
- `SR_MDU_DIV_EN` undefined:
  - Divider datapath and special-case logic are removed.
  - DIV/DIVU/REM/REMU still complete with identical latency and return 0.
  - Multiply behaviour is unchanged.

## Structure
- `sr_mdu_pkg` holds:
  - `oper` constants: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - The state enum `mdu_state_t`.
  - `MDU_ITER` = 32.
- Sub-module `sr_mdu_div_step`: combinational single restoring-division iteration. Inputs are the remainder, the dividend bit and the divisor; outputs are the next remainder and the quotient bit.

## Test plan
- MUL with 7 × (−3): `done` at E32 and `result` = 0xFFFF_FFEB. Also MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000. MULHSU 0xFFFF_FFFF × 2 → 0xFFFF_FFFF.
- DIV −7 / 2 → 0xFFFF_FFFD and REM → 0xFFFF_FFFF. DIVU 100 / 7 → 14 and REMU → 2.
- DIV by 0 with srcA = 5 → 0xFFFF_FFFF and REM → 5. Also DIV 0x8000_0000 / −1 → 0x8000_0000 and REM → 0. Latency is still 32.
- Holding `start` high continuously accepts exactly once per 34 cycles. Changing srcA mid-CALC does not change `result`.
- `rst` pulsed at E10 gives `busy` = 0 and `done` = 0 immediately, with no `done` pulse afterwards. A new start then completes normally. With `SR_MDU_DIV_EN` undefined, DIV 9 / 3 → 0.
